// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for fetch and data ports
// Data port has priority; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              owner_d_q, owner_d_d;
    logic              starve_sat;
    logic              fetch_wins;

    assign starve_sat = (starve_q == SW'(STARVE_MAX));
    assign fetch_wins = if_req && (!d_req || starve_sat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lat_q     <= '0;
            starve_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            owner_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            owner_d_q <= owner_d_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        starve_d  = starve_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        owner_d_d = owner_d_q;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Gating with rst_n keeps grants silent while reset is asserted.
                if (rst_n && (if_req || d_req)) begin
                    if (fetch_wins) begin
                        if_gnt    = 1'b1;
                        addr_d    = if_addr;
                        we_d      = 1'b0;
                        wdata_d   = '0;
                        owner_d_d = 1'b0;
                        starve_d  = '0;
                    end else begin
                        d_gnt     = 1'b1;
                        addr_d    = d_addr;
                        we_d      = d_we;
                        wdata_d   = d_wdata;
                        owner_d_d = 1'b1;
                        if (!if_req) begin
                            starve_d = '0;
                        end else if (!starve_sat) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                lat_d   = '0;
                state_d = (MEM_LAT == 1) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LW'(MEM_LAT - 2)) begin
                    state_d = S_RESP;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = (state_q == S_ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_rvalid = (state_q == S_RESP) && !owner_d_q;
    assign d_rvalid  = (state_q == S_RESP) && owner_d_q;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    // Store acks carry no data.
    assign d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        port_d;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // DUT A: MEM_LAT=2
    logic        a_if_req = 0, a_d_req = 0, a_d_we = 0;
    logic [31:0] a_if_addr = 0, a_d_addr = 0, a_d_wdata = 0;
    logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    assign a_mem_rdata = mem_model(a_mem_addr);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    // DUT B: MEM_LAT=1
    logic        b_if_req = 0, b_d_req = 0, b_d_we = 0;
    logic [31:0] b_if_addr = 0, b_d_addr = 0, b_d_wdata = 0;
    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    assign b_mem_rdata = mem_model(b_mem_addr);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_sample();
        @(negedge clk);
        #1;
    endtask

    // Response monitors: pop the scoreboard whenever an rvalid appears.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && (a_if_rvalid || a_d_rvalid)) begin
            if (sb_a.size() == 0) begin
                chk("a_spurious_rvalid", {a_if_rvalid, a_d_rvalid}, 2'b00);
            end else begin
                e = sb_a.pop_front();
                chk("a_rsp_both", {a_if_rvalid, a_d_rvalid}, e.port_d ? 2'b01 : 2'b10);
                chk("a_rsp_data", e.port_d ? a_d_rdata : a_if_rdata, e.data);
                chk("a_nonowner_rdata", e.port_d ? a_if_rdata : a_d_rdata, 32'h0);
            end
        end
        if (rst_n && (b_if_rvalid || b_d_rvalid)) begin
            if (sb_b.size() == 0) begin
                chk("b_spurious_rvalid", {b_if_rvalid, b_d_rvalid}, 2'b00);
            end else begin
                e = sb_b.pop_front();
                chk("b_rsp_port", {b_if_rvalid, b_d_rvalid}, e.port_d ? 2'b01 : 2'b10);
                chk("b_rsp_data", e.port_d ? b_d_rdata : b_if_rdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_d [10];
        int   g;
        int   last_g;
        int   ng;
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        #1;
        chk("reset_outs", {a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy}, 7'b0);
        chk("reset_bus", {a_mem_addr, a_mem_wdata}, 64'h0);
        chk("reset_rdata", {a_if_rdata, a_d_rdata}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: single fetch
        a_if_req = 1; a_if_addr = 32'h100;
        sb_a.push_back('{1'b0, 32'h00500093});
        #1;
        chk("t1_if_gnt", {a_if_gnt, a_d_gnt, a_busy}, 3'b100);
        @(negedge clk); a_if_req = 0; #1;
        chk("t1_issue", {a_mem_en, a_mem_we, a_busy}, 3'b101);
        chk("t1_mem_addr", a_mem_addr, 32'h100);
        cyc_sample();
        chk("t1_wait_en", {a_mem_en, a_if_rvalid}, 2'b00);
        cyc_sample();
        chk("t1_rvalid", a_if_rvalid, 1'b1);
        chk("t1_rdata", a_if_rdata, 32'h00500093);
        cyc_sample();
        chk("t1_idle", {a_busy, a_if_rvalid}, 2'b00);

        // T2: simultaneous fetch and load, data wins
        @(negedge clk);
        a_if_req = 1; a_if_addr = 32'h204; a_d_req = 1; a_d_we = 0; a_d_addr = 32'h40;
        sb_a.push_back('{1'b1, mem_model(32'h40)});
        #1;
        chk("t2_gnt", {a_if_gnt, a_d_gnt}, 2'b01);
        @(negedge clk); a_d_req = 0; #1;
        chk("t2_no_if_gnt1", a_if_gnt, 1'b0);
        cyc_sample();
        chk("t2_no_if_gnt2", a_if_gnt, 1'b0);
        cyc_sample();
        chk("t2_d_rvalid", {a_d_rvalid, a_if_gnt}, 2'b10);
        cyc_sample();
        chk("t2_if_gnt", {a_if_gnt, a_d_gnt}, 2'b10);
        sb_a.push_back('{1'b0, mem_model(32'h204)});
        @(negedge clk); a_if_req = 0; #1;
        cyc_sample();
        cyc_sample();
        chk("t2_if_rvalid", a_if_rvalid, 1'b1);

        // T3: store
        @(negedge clk);
        a_d_req = 1; a_d_we = 1; a_d_addr = 32'h40; a_d_wdata = 32'hDEADBEEF;
        sb_a.push_back('{1'b1, 32'h0});
        #1;
        chk("t3_d_gnt", a_d_gnt, 1'b1);
        @(negedge clk); a_d_req = 0; a_d_we = 0; #1;
        chk("t3_issue", {a_mem_en, a_mem_we}, 2'b11);
        chk("t3_wdata", a_mem_wdata, 32'hDEADBEEF);
        chk("t3_addr", a_mem_addr, 32'h40);
        cyc_sample();
        cyc_sample();
        chk("t3_ack", {a_d_rvalid, a_d_rdata}, {1'b1, 32'h0});
        cyc_sample();

        // T4: starvation ordering with both requests held
        @(negedge clk);
        a_if_req = 1; a_if_addr = 32'h200; a_d_req = 1; a_d_addr = 32'h80;
        #1;
        g = 0;
        for (int i = 0; i < 100 && g < 10; i++) begin
            if (i > 0) cyc_sample();
            if (a_if_gnt || a_d_gnt) begin
                chk("t4_one_gnt", a_if_gnt & a_d_gnt, 1'b0);
                chk($sformatf("t4_order_%0d", g), a_d_gnt, exp_d[g]);
                sb_a.push_back('{exp_d[g], exp_d[g] ? mem_model(32'h80) : mem_model(32'h200)});
                g++;
            end
        end
        if (g < 10) chk("t4_timeout", g, 10);
        @(negedge clk); a_if_req = 0; a_d_req = 0;
        repeat (5) @(negedge clk);
        #1;
        chk("t4_drained_idle", a_busy, 1'b0);

        // T5: reset during WAIT
        @(negedge clk);
        a_if_req = 1; a_if_addr = 32'h300;
        #1;
        chk("t5_gnt", a_if_gnt, 1'b1);
        @(negedge clk); a_if_req = 0;
        cyc_sample();
        chk("t5_in_wait", {a_busy, a_mem_en}, 2'b10);
        rst_n = 0;
        #1;
        chk("t5_rst_outs", {a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy}, 7'b0);
        chk("t5_rst_bus", {a_mem_addr, a_mem_wdata}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            cyc_sample();
            chk("t5_no_rvalid", {a_if_rvalid, a_d_rvalid, a_busy}, 3'b000);
        end
        @(negedge clk);
        a_if_req = 1; a_if_addr = 32'h104;
        sb_a.push_back('{1'b0, mem_model(32'h104)});
        #1;
        chk("t5_post_gnt", a_if_gnt, 1'b1);
        @(negedge clk); a_if_req = 0;
        cyc_sample();
        cyc_sample();
        chk("t5_post_rvalid", a_if_rvalid, 1'b1);

        // T6: MEM_LAT=1 back-to-back fetches
        @(negedge clk);
        b_if_req = 1; b_if_addr = 32'h400;
        #1;
        ng = 0; last_g = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            if (i > 0) cyc_sample();
            if (b_if_rvalid) chk("t6_rvalid_lat", cyc - last_g, 2);
            if (b_if_gnt) begin
                if (ng > 0) chk("t6_gnt_gap", cyc - last_g, 3);
                sb_b.push_back('{1'b0, mem_model(32'h400)});
                last_g = cyc;
                ng++;
            end
        end
        if (ng < 4) chk("t6_timeout", ng, 4);
        @(negedge clk); b_if_req = 0;
        repeat (4) @(negedge clk);
        #1;
        chk("t6_idle", b_busy, 1'b0);

        repeat (3) @(negedge clk);
        #3;
        chk("sb_a_drained", sb_a.size(), 0);
        chk("sb_b_drained", sb_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
